apb_controller: RTL and testbench
=================================

# apb_controller

Bridge-side APB sequencer for the AHB-to-APB bridge. Accepts qualified AHB transfers from the AHB slave interface and runs the APB setup/enable protocol. Drives the select, enable, write, address and write-data signals consumed by the APB interface stage. Stretches the AHB data phase with `hreadyout` and returns `prdata` to the AHB side as `hrdata`.

## Interface
- No parameters. Address and data are 32 bits; slave select is 3 bits, one-hot.
- `hclk` in 1: bridge clock, rising edge.
- `hresetn` in 1: synchronous, active-low reset.
- `valid` in 1: upstream indicates a qualified AHB address phase (NONSEQ/SEQ, `hready` high, address in range).
- `hwrite` in 1: direction of the address phase: 1 = write.
- `haddr` in 32: AHB address for the current address phase.
- `hwdata` in 32: AHB write data, valid during the write data phase.
- `tempselx` in 3: decoded one-hot slave select for `haddr`.
- `prdata` in 32: read data returned by the APB interface stage.
- `pselx` out 3: APB slave select.
- `penable` out 1: APB enable.
- `pwrite` out 1: APB direction.
- `paddr` out 32: APB address.
- `pwdata` out 32: APB write data.
- `hreadyout` out 1: AHB ready; low stretches the data phase.
- `hrdata` out 32: AHB read data.

## Operation
- **States:** ST_IDLE, ST_READ, ST_RENABLE, ST_WWAIT, ST_WRITE, ST_WENABLE.
- **Decision states:** ST_IDLE, ST_RENABLE and ST_WENABLE. In these states:
  - `valid` && !`hwrite` → ST_READ.
  - `valid` && `hwrite` → ST_WWAIT.
  - Otherwise → ST_IDLE.
  - On `valid`, capture `haddr` into addr_r and `tempselx` into sel_r.
  - `valid` is sampled only in these states; it is ignored in every other state.
- **Fixed transitions:**
  - ST_READ → ST_RENABLE.
  - ST_WWAIT → ST_WRITE; `hwdata` is captured into wdata_r on this edge.
  - ST_WRITE → ST_WENABLE.
- **Outputs per state** (pselx, penable, pwrite, hreadyout):
  - ST_IDLE: 0, 0, hold, 1.
  - ST_READ: sel_r, 0, 0, 0.
  - ST_RENABLE: sel_r, 1, 0, 1.
  - ST_WWAIT: 0, 0, hold, 0.
  - ST_WRITE: sel_r, 0, 1, 0.
  - ST_WENABLE: sel_r, 1, 1, 1.
- **Address and data outputs:**
  - `paddr` = addr_r at all times.
  - `pwdata` = wdata_r at all times.
  - Both hold their last value in ST_IDLE.
- **Read data:** `hrdata` = `prdata` in ST_RENABLE, else 32'h0.
- **Output registration:** every output except `hrdata` is a function of registered state only; no combinational path from AHB inputs to APB outputs.
- **Reset:** `hresetn` low at a rising edge has the following effect:
  - state → ST_IDLE; addr_r, sel_r and wdata_r → 0.
  - `pselx`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0, `hreadyout`=1, `hrdata`=0.
  - Applies mid-transfer as well: the transfer is aborted with no APB enable phase, and IDLE outputs appear the cycle after the edge.

## Timing
- **Read:**
  - Address phase sampled in cycle N (ST_IDLE).
  - N+1: ST_READ (setup, `hreadyout`=0).
  - N+2: ST_RENABLE (enable, `hreadyout`=1, `hrdata` valid).
  - AHB completion is 2 cycles after the address phase.
- **Write:**
  - Address phase sampled in N.
  - N+1: ST_WWAIT (`hwdata` sampled at the end of this cycle).
  - N+2: ST_WRITE (setup).
  - N+3: ST_WENABLE (enable, `hreadyout`=1).
  - AHB completion is 3 cycles after the address phase.
- **Back-to-back transfers:**
  - A new address phase may overlap the final data-phase cycle (ST_RENABLE or ST_WENABLE).
  - It is captured there and its setup starts the next cycle, with no idle gap.
- **APB rules:**
  - Every enable phase is preceded by exactly one setup cycle with the same `pselx`, `paddr` and `pwrite`.
  - `penable` is never high for more than one consecutive cycle per transfer.
- **Reset timing:** release takes effect at the first rising edge with `hresetn` high; `valid` is sampled in that cycle.

## Test plan
- **Reset:** hold `hresetn`=0 for 2 cycles with `valid`=1 → all outputs 0 except `hreadyout`=1; state ST_IDLE.
- **Single read:** `haddr`=32'h8000_0010, `tempselx`=3'b001, `hwrite`=0 → N+1: `pselx`=001, `penable`=0, `hreadyout`=0. N+2: `penable`=1, `hreadyout`=1, `hrdata`=32'd25 with `prdata` tied to 25.
- **Single write:** `haddr`=32'h8400_0004, `tempselx`=3'b010, `hwdata`=32'hDEAD_BEEF in N+1 → N+2: `pwrite`=1, `pwdata`=DEADBEEF, `penable`=0. N+3: `penable`=1, `hreadyout`=1.
- **Back-to-back:** write to 32'h8000_0000 then read 32'h8800_0008 presented in the ST_WENABLE cycle → read setup on the next cycle with `pselx`=3'b100, `paddr`=8800_0008, and no idle cycle.
- **Ignored valid:** assert `valid` with a new address during ST_READ and ST_WWAIT → not captured; `paddr` unchanged until the next decision state.
- **Mid-transfer reset:** assert `hresetn`=0 in ST_WRITE → next cycle `pselx`=0, `penable`=0, `hreadyout`=1; no enable phase is ever issued for that write.

Source files
------------

// File: rtl/apb_controller.sv
// APB setup/enable sequencer for the AHB-to-APB bridge: turns qualified AHB
// address phases into APB transfers and stretches the AHB data phase.
module apb_controller (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        valid,
    input  logic        hwrite,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [2:0]  tempselx,
    input  logic [31:0] prdata,
    output logic [2:0]  pselx,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        hreadyout,
    output logic [31:0] hrdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RENABLE,
        ST_WWAIT,
        ST_WRITE,
        ST_WENABLE
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        capture;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [2:0]  sel_reg;
    logic [2:0]  pselx_reg;
    logic        penable_reg;
    logic        pwrite_reg;
    logic        hreadyout_reg;

    // valid is only looked at in the three states where a transfer may start
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid) begin
                    capture    = 1'b1;
                    state_next = hwrite ? ST_WWAIT : ST_READ;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_READ:  state_next = ST_RENABLE;
            ST_WWAIT: state_next = ST_WRITE;
            ST_WRITE: state_next = ST_WENABLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_reg
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= 32'h0;
            wdata_reg     <= 32'h0;
            sel_reg       <= 3'b000;
            pselx_reg     <= 3'b000;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            hreadyout_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                addr_reg <= haddr;
                sel_reg  <= tempselx;
            end
            if (state_reg == ST_WWAIT) begin
                wdata_reg <= hwdata;
            end
            case (state_next)
                ST_IDLE: begin
                    pselx_reg     <= 3'b000;
                    penable_reg   <= 1'b0;
                    hreadyout_reg <= 1'b1;
                end
                ST_READ: begin
                    // sel_reg is being loaded on this same edge
                    pselx_reg     <= tempselx;
                    penable_reg   <= 1'b0;
                    pwrite_reg    <= 1'b0;
                    hreadyout_reg <= 1'b0;
                end
                ST_RENABLE: begin
                    pselx_reg     <= sel_reg;
                    penable_reg   <= 1'b1;
                    pwrite_reg    <= 1'b0;
                    hreadyout_reg <= 1'b1;
                end
                ST_WWAIT: begin
                    pselx_reg     <= 3'b000;
                    penable_reg   <= 1'b0;
                    hreadyout_reg <= 1'b0;
                end
                ST_WRITE: begin
                    pselx_reg     <= sel_reg;
                    penable_reg   <= 1'b0;
                    pwrite_reg    <= 1'b1;
                    hreadyout_reg <= 1'b0;
                end
                ST_WENABLE: begin
                    pselx_reg     <= sel_reg;
                    penable_reg   <= 1'b1;
                    pwrite_reg    <= 1'b1;
                    hreadyout_reg <= 1'b1;
                end
                default: begin
                    pselx_reg     <= 3'b000;
                    penable_reg   <= 1'b0;
                    hreadyout_reg <= 1'b1;
                end
            endcase
        end
    end

    assign pselx     = pselx_reg;
    assign penable   = penable_reg;
    assign pwrite    = pwrite_reg;
    assign hreadyout = hreadyout_reg;
    assign paddr     = addr_reg;
    assign pwdata    = wdata_reg;
    assign hrdata    = (state_reg == ST_RENABLE) ? prdata : 32'h0;

endmodule

// File: tb/tb_apb_controller.sv
// Cycle-by-cycle vector table for apb_controller with a queue scoreboard,
// followed by latency-bounded random read and write transfers.
module tb_apb_controller;

    logic        hclk = 1'b0;
    logic        hresetn, valid, hwrite;
    logic [31:0] haddr, hwdata, prdata;
    logic [2:0]  tempselx;
    logic [2:0]  pselx;
    logic        penable, pwrite, hreadyout;
    logic [31:0] paddr, pwdata, hrdata;

    apb_controller dut (
        .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite),
        .haddr(haddr), .hwdata(hwdata), .tempselx(tempselx), .prdata(prdata),
        .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .hreadyout(hreadyout), .hrdata(hrdata)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic [2:0]  psel;
        logic        pen;
        logic        pwr;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        hrdy;
        logic [31:0] hrdata;
    } exp_t;

    typedef struct {
        logic        rstn;
        logic        vld;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  tsel;
        logic [31:0] rdata;
        exp_t        exp;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic rstn, input logic vld, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] tsel, input logic [31:0] rdata,
                       input logic [2:0] e_psel, input logic e_pen, input logic e_pwr,
                       input logic [31:0] e_paddr, input logic [31:0] e_pwdata,
                       input logic e_hrdy, input logic [31:0] e_hrdata);
        vec_t v;
        v.rstn = rstn; v.vld = vld; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.tsel = tsel; v.rdata = rdata;
        v.exp = '{psel: e_psel, pen: e_pen, pwr: e_pwr, paddr: e_paddr,
                  pwdata: e_pwdata, hrdy: e_hrdy, hrdata: e_hrdata};
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic check(input string name, input logic ok, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    initial begin
        exp_t        act, e;
        logic [31:0] rnd;
        logic [31:0] su_addr;
        logic [2:0]  su_sel;
        int          lat;
        bit          seen;

        // rstn vld wr addr wdata tsel prdata | psel pen pwr paddr pwdata hrdy hrdata
        add(0,1,1,32'hA5A5_A5A5,32'h1111_1111,3'b111,32'd25, 3'b000,0,0,32'h0,32'h0,1,32'h0);
        add(0,1,1,32'hA5A5_A5A5,32'h1111_1111,3'b111,32'd25, 3'b000,0,0,32'h0,32'h0,1,32'h0);
        add(1,0,0,32'h0,32'h0,3'b000,32'd25,                 3'b000,0,0,32'h0,32'h0,1,32'h0);
        // single read
        add(1,1,0,32'h8000_0010,32'h0,3'b001,32'd25,         3'b001,0,0,32'h8000_0010,32'h0,0,32'h0);
        add(1,0,0,32'h0,32'h0,3'b000,32'd25,                 3'b001,1,0,32'h8000_0010,32'h0,1,32'd25);
        add(1,0,0,32'h0,32'h0,3'b000,32'd25,                 3'b000,0,0,32'h8000_0010,32'h0,1,32'h0);
        // single write, data arrives in the cycle after the address phase
        add(1,1,1,32'h8400_0004,32'h0,3'b010,32'd25,         3'b000,0,0,32'h8400_0004,32'h0,0,32'h0);
        add(1,0,0,32'h0,32'hDEAD_BEEF,3'b000,32'd25,         3'b010,0,1,32'h8400_0004,32'hDEAD_BEEF,0,32'h0);
        add(1,0,0,32'h0,32'h0,3'b000,32'd25,                 3'b010,1,1,32'h8400_0004,32'hDEAD_BEEF,1,32'h0);
        add(1,0,0,32'h0,32'h0,3'b000,32'd25,                 3'b000,0,1,32'h8400_0004,32'hDEAD_BEEF,1,32'h0);
        // write then back-to-back read presented during the write enable
        add(1,1,1,32'h8000_0000,32'h0,3'b001,32'd25,         3'b000,0,1,32'h8000_0000,32'hDEAD_BEEF,0,32'h0);
        add(1,0,0,32'h0,32'h1234_5678,3'b000,32'd25,         3'b001,0,1,32'h8000_0000,32'h1234_5678,0,32'h0);
        add(1,0,0,32'h0,32'h0,3'b000,32'd25,                 3'b001,1,1,32'h8000_0000,32'h1234_5678,1,32'h0);
        add(1,1,0,32'h8800_0008,32'h0,3'b100,32'd25,         3'b100,0,0,32'h8800_0008,32'h1234_5678,0,32'h0);
        // valid during ST_READ is ignored
        add(1,1,1,32'hDEAD_0000,32'h0,3'b010,32'd99,         3'b100,1,0,32'h8800_0008,32'h1234_5678,1,32'd99);
        add(1,1,1,32'h8C00_000C,32'h0,3'b010,32'd25,         3'b000,0,0,32'h8C00_000C,32'h1234_5678,0,32'h0);
        // valid during ST_WWAIT is ignored
        add(1,1,0,32'hFFFF_0000,32'hCAFE_F00D,3'b001,32'd25, 3'b010,0,1,32'h8C00_000C,32'hCAFE_F00D,0,32'h0);
        add(1,0,0,32'h0,32'h0,3'b000,32'd25,                 3'b010,1,1,32'h8C00_000C,32'hCAFE_F00D,1,32'h0);
        // reset asserted while in ST_WRITE
        add(1,1,1,32'h9000_0000,32'h0,3'b100,32'd25,         3'b000,0,1,32'h9000_0000,32'hCAFE_F00D,0,32'h0);
        add(1,0,0,32'h0,32'h1111_2222,3'b000,32'd25,         3'b100,0,1,32'h9000_0000,32'h1111_2222,0,32'h0);
        add(0,0,0,32'h0,32'h0,3'b000,32'd25,                 3'b000,0,0,32'h0,32'h0,1,32'h0);
        add(1,0,0,32'h0,32'h0,3'b000,32'd25,                 3'b000,0,0,32'h0,32'h0,1,32'h0);

        foreach (tbl[i]) begin
            hresetn  = tbl[i].rstn;
            valid    = tbl[i].vld;
            hwrite   = tbl[i].wr;
            haddr    = tbl[i].addr;
            hwdata   = tbl[i].wdata;
            tempselx = tbl[i].tsel;
            prdata   = tbl[i].rdata;
            sb.push_back(tbl[i].exp);
            step();
            act = '{psel: pselx, pen: penable, pwr: pwrite, paddr: paddr,
                    pwdata: pwdata, hrdy: hreadyout, hrdata: hrdata};
            e = sb.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL vec%0d: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h hrdy=%b hrdata=%h want psel=%b pen=%b pwr=%b paddr=%h pwdata=%h hrdy=%b hrdata=%h",
                         i, act.psel, act.pen, act.pwr, act.paddr, act.pwdata, act.hrdy, act.hrdata,
                         e.psel, e.pen, e.pwr, e.paddr, e.pwdata, e.hrdy, e.hrdata);
            end
        end

        // Random read: enable must come 2 cycles after the address phase
        rnd = $urandom;
        valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0020; tempselx = 3'b001; prdata = rnd;
        step();
        valid = 1'b0;
        su_addr = paddr; su_sel = pselx;
        lat = 1; seen = 1'b0;
        while (!seen && lat < 8) begin
            step();
            lat++;
            if (penable) seen = 1'b1;
        end
        check("rd_timeout", seen, 32'(seen), 32'd1);
        check("rd_latency", lat == 2, 32'(lat), 32'd2);
        check("rd_hrdata", hrdata === rnd, hrdata, rnd);
        check("rd_setup_match", (su_addr === paddr) && (su_sel === pselx), su_addr, paddr);
        step();
        check("rd_single_enable", penable === 1'b0, 32'(penable), 32'd0);

        // Random write: enable must come 3 cycles after the address phase
        rnd = $urandom;
        valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0040; tempselx = 3'b010;
        step();
        valid = 1'b0; hwdata = rnd;
        lat = 1; seen = 1'b0;
        while (!seen && lat < 8) begin
            step();
            lat++;
            hwdata = 32'h0;
            if (penable) seen = 1'b1;
        end
        check("wr_timeout", seen, 32'(seen), 32'd1);
        check("wr_latency", lat == 3, 32'(lat), 32'd3);
        check("wr_pwdata", pwdata === rnd, pwdata, rnd);
        check("wr_paddr", paddr === 32'h8400_0040, paddr, 32'h8400_0040);
        step();
        check("wr_idle_ready", hreadyout === 1'b1 && penable === 1'b0, 32'(hreadyout), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
